// File: rtl/cpu10_pkg.sv
// Shared definitions for the 10-bit CPU: bus widths, dump framing constant and
// the RAM dump FSM state encoding.
package cpu10_pkg;

  localparam int unsigned DATA_W = 10;
  localparam int unsigned ADDR_W = 10;

  localparam logic [7:0] DUMP_HDR = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    RD,
    SEND_HI,
    SEND_LO,
    CSUM,
    DONE
  } dump_state_t;

endpackage

// File: rtl/ram_dump_tx.sv
// Post-halt data RAM readback: walks a fixed address window and streams it as
// a framed byte stream (header, hi/lo byte per word, 8-bit checksum).
module ram_dump_tx
  import cpu10_pkg::*;
#(
  parameter logic [ADDR_W-1:0] START_ADDR = 10'h000,
  parameter int unsigned       DUMP_WORDS = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_rd_en,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [7:0]        o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned     IDX_W    = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DUMP_WORDS - 1);

  dump_state_t       r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [7:0]        r_csum, w_csum_nxt;
  logic [7:0]        r_lo, w_lo_nxt;
  logic [7:0]        r_out_data, w_out_data_nxt;
  logic              r_out_valid, w_out_valid_nxt;
  logic              r_rd_en, w_rd_en_nxt;
  logic [ADDR_W-1:0] r_rd_addr, w_rd_addr_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;

  logic [ADDR_W-1:0] w_addr_cur;
  logic [ADDR_W-1:0] w_addr_inc;
  logic [7:0]        w_sum;
  logic              w_xfer;

  // Address arithmetic wraps naturally at ADDR_W bits.
  assign w_addr_cur = START_ADDR + ADDR_W'(r_idx);
  assign w_addr_inc = w_addr_cur + ADDR_W'(1);
  assign w_sum      = r_csum + r_out_data;
  assign w_xfer     = r_out_valid & i_out_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_csum      <= '0;
      r_lo        <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_csum      <= w_csum_nxt;
      r_lo        <= w_lo_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_rd_en     <= w_rd_en_nxt;
      r_rd_addr   <= w_rd_addr_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Next-state logic also computes the registered output values for the state being entered.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_csum_nxt      = r_csum;
    w_lo_nxt        = r_lo;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    w_rd_en_nxt     = 1'b0;
    w_rd_addr_nxt   = r_rd_addr;
    w_busy_nxt      = r_busy;
    w_done_nxt      = r_done;

    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt     = HDR;
          w_idx_nxt       = '0;
          w_csum_nxt      = '0;
          w_out_data_nxt  = DUMP_HDR;
          w_out_valid_nxt = 1'b1;
          w_busy_nxt      = 1'b1;
        end
      end
      HDR: begin
        if (w_xfer) begin
          w_state_nxt     = RD;
          w_out_valid_nxt = 1'b0;
          w_rd_en_nxt     = 1'b1;
          w_rd_addr_nxt   = w_addr_cur;
        end
      end
      RD: begin
        w_state_nxt     = SEND_HI;
        w_lo_nxt        = i_rd_data[7:0];
        w_out_data_nxt  = {6'b0, i_rd_data[9:8]};
        w_out_valid_nxt = 1'b1;
      end
      SEND_HI: begin
        if (w_xfer) begin
          w_state_nxt    = SEND_LO;
          w_csum_nxt     = w_sum;
          w_out_data_nxt = r_lo;
        end
      end
      SEND_LO: begin
        if (w_xfer) begin
          w_csum_nxt = w_sum;
          if (r_idx == IDX_LAST) begin
            w_state_nxt    = CSUM;
            w_out_data_nxt = w_sum;
          end else begin
            w_state_nxt     = RD;
            w_idx_nxt       = r_idx + IDX_W'(1);
            w_out_valid_nxt = 1'b0;
            w_rd_en_nxt     = 1'b1;
            w_rd_addr_nxt   = w_addr_inc;
          end
        end
      end
      CSUM: begin
        if (w_xfer) begin
          w_state_nxt     = DONE;
          w_out_valid_nxt = 1'b0;
          w_busy_nxt      = 1'b0;
          w_done_nxt      = 1'b1;
        end
      end
      DONE: begin
        // One frame per start assertion: wait for start to drop before re-arming.
        if (!i_start) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign o_rd_addr   = r_rd_addr;
  assign o_rd_en     = r_rd_en;
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_ram_dump_tx.sv
// Directed bench for ram_dump_tx: three instances cover the default window,
// an address window that wraps past 3FF, and a single-word frame.
module tb_ram_dump_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance a: START_ADDR=000, DUMP_WORDS=4
  logic       start_a, ready_a, rd_en_a, valid_a, busy_a, done_a;
  logic [9:0] addr_a, rdata_a;
  logic [7:0] byte_a;
  logic [9:0] ram_a [0:1023];
  assign rdata_a = ram_a[addr_a];

  // Instance w: START_ADDR=3FE, DUMP_WORDS=4
  logic       start_w, ready_w, rd_en_w, valid_w, busy_w, done_w;
  logic [9:0] addr_w, rdata_w;
  logic [7:0] byte_w;
  logic [9:0] ram_w [0:1023];
  assign rdata_w = ram_w[addr_w];

  // Instance m: START_ADDR=000, DUMP_WORDS=1
  logic       start_m, ready_m, rd_en_m, valid_m, busy_m, done_m;
  logic [9:0] addr_m, rdata_m;
  logic [7:0] byte_m;
  logic [9:0] ram_m [0:1023];
  assign rdata_m = ram_m[addr_m];

  ram_dump_tx #(.START_ADDR(10'h000), .DUMP_WORDS(4)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a), .o_rd_addr(addr_a), .o_rd_en(rd_en_a),
    .i_rd_data(rdata_a), .o_out_data(byte_a), .o_out_valid(valid_a), .i_out_ready(ready_a),
    .o_busy(busy_a), .o_done(done_a));

  ram_dump_tx #(.START_ADDR(10'h3FE), .DUMP_WORDS(4)) u_dut_w (
    .i_clk(clk), .i_rst(rst), .i_start(start_w), .o_rd_addr(addr_w), .o_rd_en(rd_en_w),
    .i_rd_data(rdata_w), .o_out_data(byte_w), .o_out_valid(valid_w), .i_out_ready(ready_w),
    .o_busy(busy_w), .o_done(done_w));

  ram_dump_tx #(.START_ADDR(10'h000), .DUMP_WORDS(1)) u_dut_m (
    .i_clk(clk), .i_rst(rst), .i_start(start_m), .o_rd_addr(addr_m), .o_rd_en(rd_en_m),
    .i_rd_data(rdata_m), .o_out_data(byte_m), .o_out_valid(valid_m), .i_out_ready(ready_m),
    .o_busy(busy_m), .o_done(done_m));

  logic [7:0] bq_a [$];
  logic [7:0] bq_w [$];
  logic [7:0] bq_m [$];
  logic [9:0] aq_a [$];
  logic [9:0] aq_w [$];

  logic [7:0] exp_a [10] = '{8'hA5, 8'h03, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h00, 8'h00, 8'hAB, 8'hB0};
  logic [7:0] exp_w [10] = '{8'hA5, 8'h01, 8'h23, 8'h00, 8'hFF, 8'h03, 8'h00, 8'h00, 8'h10, 8'h36};
  logic [7:0] exp_m [4]  = '{8'hA5, 8'h01, 8'h55, 8'h56};
  logic [9:0] exp_wa [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};

  // Inputs change 1 time unit after posedge, so at negedge valid&ready means a transfer on the next posedge.
  always @(negedge clk) begin
    if (valid_a && ready_a) bq_a.push_back(byte_a);
    if (valid_w && ready_w) bq_w.push_back(byte_w);
    if (valid_m && ready_m) bq_m.push_back(byte_m);
    if (rd_en_a) aq_a.push_back(addr_a);
    if (rd_en_w) aq_w.push_back(addr_w);
  end

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return done_a;
      1:       return done_w;
      default: return done_m;
    endcase
  endfunction

  // Raise start for one instance; report the edge number (0 = start-sampling edge) after which done is seen.
  task automatic run_frame(input int sel, output int done_edge);
    case (sel)
      0:       start_a = 1'b1;
      1:       start_w = 1'b1;
      default: start_m = 1'b1;
    endcase
    done_edge = -1;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (done_of(sel)) begin
        done_edge = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start_a = 1'b0; start_w = 1'b0; start_m = 1'b0;
    ready_a = 1'b1; ready_w = 1'b1; ready_m = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_a); end
    checks++; if (byte_a !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", byte_a); end
    checks++; if (rd_en_a !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%b exp=0", rd_en_a); end
    checks++; if (addr_a !== 10'h000) begin errors++; $display("FAIL reset_rd_addr got=%h exp=000", addr_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done_a); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_normal;
    int de;
    logic [7:0] got;
    bq_a.delete(); aq_a.delete();
    run_frame(0, de);
    checks++; if (de != 14) begin errors++; $display("FAIL normal_done_edge got=%0d exp=14", de); end
    checks++; if (bq_a.size() != 10) begin errors++; $display("FAIL normal_len got=%0d exp=10", bq_a.size()); end
    for (int i = 0; i < 10; i++) begin
      got = (i < bq_a.size()) ? bq_a[i] : 8'hxx;
      checks++; if (got !== exp_a[i]) begin errors++; $display("FAIL normal_byte%0d got=%h exp=%h", i, got, exp_a[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= aq_a.size() || aq_a[i] !== 10'(i)) begin
        errors++; $display("FAIL normal_rd_addr%0d got=%h exp=%h", i, (i < aq_a.size()) ? aq_a[i] : 10'hxxx, 10'(i));
      end
    end
  endtask

  task automatic test_rearm;
    int de;
    logic [7:0] got;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (bq_a.size() != 10) begin errors++; $display("FAIL rearm_no_second_frame got=%0d bytes exp=10", bq_a.size()); end
    checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL rearm_done_held got=%b exp=1", done_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rearm_busy got=%b exp=0", busy_a); end
    start_a = 1'b0;
    @(posedge clk); #1;
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL rearm_done_clear got=%b exp=0", done_a); end
    bq_a.delete(); aq_a.delete();
    run_frame(0, de);
    checks++; if (de != 14) begin errors++; $display("FAIL rearm_done_edge got=%0d exp=14", de); end
    checks++; if (bq_a.size() != 10) begin errors++; $display("FAIL rearm_len got=%0d exp=10", bq_a.size()); end
    for (int i = 0; i < 10; i++) begin
      got = (i < bq_a.size()) ? bq_a[i] : 8'hxx;
      checks++; if (got !== exp_a[i]) begin errors++; $display("FAIL rearm_byte%0d got=%h exp=%h", i, got, exp_a[i]); end
    end
  endtask

  task automatic test_backpressure;
    int de, phase, stall_n;
    logic prev_stalled;
    logic [7:0] prev_data, got;
    start_a = 1'b0;
    @(posedge clk); #1;
    bq_a.delete(); aq_a.delete();
    ready_a = 1'b1;
    start_a = 1'b1;
    phase = 0; stall_n = 0; prev_stalled = 1'b0; prev_data = 8'h00; de = -1;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      if (prev_stalled) begin
        checks++;
        if (valid_a !== 1'b1 || byte_a !== prev_data) begin
          errors++; $display("FAIL bp_hold got valid=%b data=%h exp valid=1 data=%h", valid_a, byte_a, prev_data);
        end
      end
      if (done_a) begin
        de = n;
        break;
      end
      case (phase)
        0: if (bq_a.size() == 5 && valid_a) begin
             checks++; if (byte_a !== 8'h02) begin errors++; $display("FAIL bp_stall_byte got=%h exp=02", byte_a); end
             phase = 1; stall_n = 1; ready_a = 1'b0;
           end
        1: if (stall_n == 5) begin phase = 2; ready_a = 1'b1; end
           else stall_n++;
        default: ready_a = ~ready_a;
      endcase
      prev_stalled = valid_a && !ready_a;
      prev_data = byte_a;
    end
    ready_a = 1'b1;
    checks++; if (de < 0 || phase != 2) begin errors++; $display("FAIL bp_completion got done_edge=%0d phase=%0d exp done and phase=2", de, phase); end
    checks++; if (bq_a.size() != 10) begin errors++; $display("FAIL bp_len got=%0d exp=10", bq_a.size()); end
    for (int i = 0; i < 10; i++) begin
      got = (i < bq_a.size()) ? bq_a[i] : 8'hxx;
      checks++; if (got !== exp_a[i]) begin errors++; $display("FAIL bp_byte%0d got=%h exp=%h", i, got, exp_a[i]); end
    end
  endtask

  task automatic test_reset_mid;
    int de;
    logic found;
    logic [7:0] got;
    start_a = 1'b0;
    @(posedge clk); #1;
    bq_a.delete(); aq_a.delete();
    start_a = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (bq_a.size() == 4 && valid_a) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (!found || byte_a !== 8'h01) begin errors++; $display("FAIL rstmid_reach_lo found=%b data=%h exp data=01", found, byte_a); end
    rst = 1'b1;
    #1;
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", valid_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy_a); end
    checks++; if (byte_a !== 8'h00) begin errors++; $display("FAIL rstmid_data got=%h exp=00", byte_a); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bq_a.delete(); aq_a.delete();
    run_frame(0, de);
    checks++; if (de != 14) begin errors++; $display("FAIL rstmid_done_edge got=%0d exp=14", de); end
    checks++; if (aq_a.size() != 4 || aq_a[0] !== 10'h000) begin
      errors++; $display("FAIL rstmid_first_addr got=%h count=%0d exp=000 count=4", (aq_a.size() > 0) ? aq_a[0] : 10'hxxx, aq_a.size());
    end
    for (int i = 0; i < 10; i++) begin
      got = (i < bq_a.size()) ? bq_a[i] : 8'hxx;
      checks++; if (got !== exp_a[i]) begin errors++; $display("FAIL rstmid_byte%0d got=%h exp=%h", i, got, exp_a[i]); end
    end
  endtask

  task automatic test_wrap;
    int de;
    logic [7:0] got;
    logic [9:0] gota;
    bq_w.delete(); aq_w.delete();
    run_frame(1, de);
    checks++; if (de != 14) begin errors++; $display("FAIL wrap_done_edge got=%0d exp=14", de); end
    checks++; if (aq_w.size() != 4) begin errors++; $display("FAIL wrap_read_count got=%0d exp=4", aq_w.size()); end
    for (int i = 0; i < 4; i++) begin
      gota = (i < aq_w.size()) ? aq_w[i] : 10'hxxx;
      checks++; if (gota !== exp_wa[i]) begin errors++; $display("FAIL wrap_rd_addr%0d got=%h exp=%h", i, gota, exp_wa[i]); end
    end
    for (int i = 0; i < 10; i++) begin
      got = (i < bq_w.size()) ? bq_w[i] : 8'hxx;
      checks++; if (got !== exp_w[i]) begin errors++; $display("FAIL wrap_byte%0d got=%h exp=%h", i, got, exp_w[i]); end
    end
  endtask

  task automatic test_min;
    int de;
    logic [7:0] got;
    bq_m.delete();
    run_frame(2, de);
    checks++; if (de != 5) begin errors++; $display("FAIL min_done_edge got=%0d exp=5", de); end
    checks++; if (bq_m.size() != 4) begin errors++; $display("FAIL min_len got=%0d exp=4", bq_m.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < bq_m.size()) ? bq_m[i] : 8'hxx;
      checks++; if (got !== exp_m[i]) begin errors++; $display("FAIL min_byte%0d got=%h exp=%h", i, got, exp_m[i]); end
    end
  endtask

  initial begin
    ram_a[10'h000] = 10'h3FF;
    ram_a[10'h001] = 10'h001;
    ram_a[10'h002] = 10'h200;
    ram_a[10'h003] = 10'h0AB;
    ram_w[10'h3FE] = 10'h123;
    ram_w[10'h3FF] = 10'h0FF;
    ram_w[10'h000] = 10'h300;
    ram_w[10'h001] = 10'h010;
    ram_m[10'h000] = 10'h155;

    test_reset();
    test_normal();
    test_rearm();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    test_min();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
